my_isolation_ctrl: RTL



---
 rtl/my_isolation_pkg.sv | 21 ++
 rtl/my_valid_pipe.sv | 41 ++++
 rtl/my_isolation_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/my_isolation_pkg.sv
// Shared definitions for the operand-isolation control stage.
`timescale 1ns/1ps
package my_isolation_pkg;

  typedef enum logic [1:0] {
    ISOLATED = 2'b00,
    ACTIVE   = 2'b01,
    LINGER   = 2'b10
  } iso_state_e;

  // Smallest idle counter width that can hold the value idle_hold.
  function automatic int min_idle_cnt_width(input int idle_hold);
    int w;
    w = 1;
    while ((1 << w) <= idle_hold) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/my_valid_pipe.sv
// In-flight tracker: DEPTH-deep valid shift register with synchronous clear.
`timescale 1ns/1ps
module my_valid_pipe #(
  parameter int DEPTH = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_in,
  output logic o_tail,
  output logic o_any,
  output logic o_next_any
);

  logic [DEPTH-1:0] r_pipe;
  logic [DEPTH-1:0] w_pipe_next;

  generate
    if (DEPTH == 1) begin : g_single
      assign w_pipe_next = i_in;
    end else begin : g_multi
      assign w_pipe_next = {r_pipe[DEPTH-2:0], i_in};
    end
  endgenerate

  // Shift register; clear wins over the incoming bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe <= {DEPTH{1'b0}};
    end else if (i_clr) begin
      r_pipe <= {DEPTH{1'b0}};
    end else begin
      r_pipe <= w_pipe_next;
    end
  end

  assign o_tail     = r_pipe[DEPTH-1];
  assign o_any      = |r_pipe;
  assign o_next_any = |w_pipe_next;

endmodule

// File: rtl/my_isolation_ctrl.sv
// Operand register, in-flight tracking and pass/isolate control in front of a
// functional unit's operand-isolation cells.
`timescale 1ns/1ps
module my_isolation_ctrl
  import my_isolation_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OP_LATENCY     = 3,
  parameter int IDLE_HOLD      = 4,
  parameter int IDLE_CNT_WIDTH = 3
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iIssue_Valid,
  input  logic [DATA_WIDTH-1:0] iOperand_A,
  input  logic [DATA_WIDTH-1:0] iOperand_B,
  input  logic                  iFlush,
  output logic [DATA_WIDTH-1:0] oOperand_A,
  output logic [DATA_WIDTH-1:0] oOperand_B,
  output logic                  oIsolation_Signal,
  output logic                  oResult_Valid,
  output logic                  oBusy
);

  logic                      w_issue_acc;
  logic                      w_pipe_tail;
  logic                      w_pipe_any;
  logic                      w_pipe_next_any;
  iso_state_e                r_state;
  iso_state_e                w_state_next;
  logic [IDLE_CNT_WIDTH-1:0] r_idle_cnt;
  logic [IDLE_CNT_WIDTH-1:0] w_idle_cnt_next;
  logic [DATA_WIDTH-1:0]     r_operand_a;
  logic [DATA_WIDTH-1:0]     r_operand_b;
  logic                      r_iso;

  // A flush squashes any issue presented on the same edge.
  assign w_issue_acc = iIssue_Valid & ~iFlush;

  my_valid_pipe #(
    .DEPTH(OP_LATENCY)
  ) u_valid_pipe (
    .i_clk      (iClk),
    .i_rst_n    (iReset_n),
    .i_clr      (iFlush),
    .i_in       (w_issue_acc),
    .o_tail     (w_pipe_tail),
    .o_any      (w_pipe_any),
    .o_next_any (w_pipe_next_any)
  );

  // Operands only move on accepted issue so the FU inputs never toggle while idle.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_operand_a <= {DATA_WIDTH{1'b0}};
      r_operand_b <= {DATA_WIDTH{1'b0}};
    end else if (w_issue_acc) begin
      r_operand_a <= iOperand_A;
      r_operand_b <= iOperand_B;
    end
  end

  // State, idle counter and the registered pass/isolate output.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state    <= ISOLATED;
      r_idle_cnt <= {IDLE_CNT_WIDTH{1'b0}};
      r_iso      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_idle_cnt <= w_idle_cnt_next;
      r_iso      <= (w_state_next != ISOLATED);
    end
  end

  // Next-state and idle-counter logic.
  always_comb begin
    w_state_next    = r_state;
    w_idle_cnt_next = r_idle_cnt;
    if (iFlush) begin
      w_state_next    = ISOLATED;
      w_idle_cnt_next = {IDLE_CNT_WIDTH{1'b0}};
    end else begin
      case (r_state)
        ISOLATED: begin
          w_idle_cnt_next = {IDLE_CNT_WIDTH{1'b0}};
          if (w_issue_acc) begin
            w_state_next = ACTIVE;
          end else begin
            w_state_next = ISOLATED;
          end
        end
        ACTIVE: begin
          if (w_pipe_next_any) begin
            w_state_next    = ACTIVE;
            w_idle_cnt_next = {IDLE_CNT_WIDTH{1'b0}};
          end else if (IDLE_HOLD == 0) begin
            w_state_next    = ISOLATED;
            w_idle_cnt_next = {IDLE_CNT_WIDTH{1'b0}};
          end else begin
            w_state_next    = LINGER;
            w_idle_cnt_next = IDLE_CNT_WIDTH'(IDLE_HOLD);
          end
        end
        LINGER: begin
          if (w_issue_acc) begin
            w_state_next    = ACTIVE;
            w_idle_cnt_next = {IDLE_CNT_WIDTH{1'b0}};
          end else if (r_idle_cnt <= IDLE_CNT_WIDTH'(1)) begin
            w_state_next    = ISOLATED;
            w_idle_cnt_next = {IDLE_CNT_WIDTH{1'b0}};
          end else begin
            w_state_next    = LINGER;
            w_idle_cnt_next = r_idle_cnt - IDLE_CNT_WIDTH'(1);
          end
        end
        default: begin
          w_state_next    = ISOLATED;
          w_idle_cnt_next = {IDLE_CNT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign oOperand_A        = r_operand_a;
  assign oOperand_B        = r_operand_b;
  assign oIsolation_Signal = r_iso;
  assign oResult_Valid     = w_pipe_tail;
  assign oBusy             = w_pipe_any;

endmodule
